// File: rtl/count_event_logger.sv
// Event logger: captures counter events with a count snapshot into a FWFT FIFO drained by host pops.
// Optional timestamp column enabled by defining EVLOG_TIMESTAMP_EN.
module count_event_logger #(
  parameter int unsigned NEV   = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic           clk1,
  input  logic           reset1,
  input  logic           tick,
  input  logic [7:0]     count,
  input  logic [NEV-1:0] event_in,
  input  logic           pop,
  input  logic           clear,
  output logic [15:0]    dout,
  output logic [15:0]    ts_out,
  output logic [AW:0]    level,
  output logic           empty,
  output logic           full,
  output logic [15:0]    drop_count,
  output logic           overflow
);

  localparam logic [AW:0] FullLvl = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic          push, do_pop, accept, drop;
  logic [7:0]    ev_pad;

  always_comb begin
    ev_pad = '0;
    ev_pad[NEV-1:0] = event_in;
  end

  assign empty  = (level_q == '0);
  assign full   = (level_q == FullLvl);
  // clear overrides everything: no push, no pop, no drop accounting
  assign push   = (|event_in) && !clear;
  assign do_pop = pop && !empty && !clear;
  assign accept = push && (!full || do_pop);
  assign drop   = push && full && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    ovf_d    = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (accept && !do_pop)      level_d = level_q + (AW+1)'(1);
      else if (!accept && do_pop) level_d = level_q - (AW+1)'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately unreset; empty masks stale contents on dout.
  always_ff @(posedge clk1) begin
    if (accept) mem_q[wr_ptr_q] <= {ev_pad, count};
  end

  assign dout       = empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign level      = level_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

`ifdef EVLOG_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_mem_q [DEPTH];

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1)     ts_q <= '0;
    else if (clear) ts_q <= '0;
    else if (tick)  ts_q <= ts_q + 16'd1;
  end

  // Stores the pre-increment value when tick coincides with the push.
  always_ff @(posedge clk1) begin
    if (accept) ts_mem_q[wr_ptr_q] <= ts_q;
  end

  assign ts_out = empty ? 16'h0000 : ts_mem_q[rd_ptr_q];
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign ts_out      = 16'h0000;
`endif

endmodule

// File: tb/tb_count_event_logger.sv
// Scoreboard bench for count_event_logger: a queue model of the FIFO predicts every output.
// Timestamp checks are compiled in when EVLOG_TIMESTAMP_EN is defined.
module tb_count_event_logger;

  localparam int unsigned NEV   = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic           clk1, reset1, tick, pop, clear;
  logic [7:0]     count;
  logic [NEV-1:0] event_in;
  logic [15:0]    dout, ts_out, drop_count;
  logic [AW:0]    level;
  logic           empty, full, overflow;

  count_event_logger #(.NEV(NEV), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk1       (clk1),
    .reset1     (reset1),
    .tick       (tick),
    .count      (count),
    .event_in   (event_in),
    .pop        (pop),
    .clear      (clear),
    .dout       (dout),
    .ts_out     (ts_out),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model state: each entry is {timestamp, dout}
  logic [31:0] sb_q [$];
  logic [15:0] m_drop = '0;
  logic        m_ovf  = 1'b0;
  logic [15:0] m_ts   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_drop = '0;
    m_ovf  = 1'b0;
    m_ts   = '0;
  endtask

  task automatic check_outputs();
    logic [31:0] head;
    head = (sb_q.size() != 0) ? sb_q[0] : 32'h0;
    check("dout", 32'(dout), 32'(head[15:0]));
`ifdef EVLOG_TIMESTAMP_EN
    check("ts_out", 32'(ts_out), 32'(head[31:16]));
`else
    check("ts_out", 32'(ts_out), 32'h0);
`endif
    check("level", 32'(level), 32'(sb_q.size()));
    check("empty", 32'(empty), 32'(sb_q.size() == 0));
    check("full", 32'(full), 32'(sb_q.size() == DEPTH));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Drive one cycle of stimulus, update the model, then compare after the edge.
  task automatic step(input logic [1:0] ev, input logic [7:0] cnt, input logic pp,
                      input logic clr, input logic tk);
    event_in = ev;
    count    = cnt;
    pop      = pp;
    clear    = clr;
    tick     = tk;
    m_ovf    = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      if (pp && sb_q.size() != 0) void'(sb_q.pop_front());
      if (ev != 2'b00) begin
        if (sb_q.size() < DEPTH) sb_q.push_back({m_ts, 6'b0, ev, cnt});
        else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
      end
`ifdef EVLOG_TIMESTAMP_EN
      if (tk) m_ts = m_ts + 16'd1;
`endif
    end
    @(posedge clk1);
    #1;
    event_in = '0;
    pop      = 1'b0;
    clear    = 1'b0;
    tick     = 1'b0;
    check_outputs();
  endtask

  initial begin
    reset1   = 1'b1;
    tick     = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    count    = '0;
    event_in = '0;
    #12;
    check_outputs();
    @(negedge clk1);
    reset1 = 1'b0;

    // Mid-run asynchronous reset at level 5
    for (int i = 0; i < 5; i++) step(2'b01, 8'(i), 1'b0, 1'b0, 1'b0);
    check("level5", 32'(level), 32'd5);
    #2;
    reset1 = 1'b1;
    #1;
    model_reset();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    @(negedge clk1);
    reset1 = 1'b0;

    // Single event then pop
    step(2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ev01_dout", 32'(dout), 32'h0100);
    step(2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("pop_empty", 32'(empty), 32'd1);

    // Simultaneous events share one entry
    step(2'b11, 8'h80, 1'b0, 1'b0, 1'b0);
    check("ev11_dout", 32'(dout), 32'h0380);
    check("ev11_level", 32'(level), 32'd1);
    step(2'b00, 8'h00, 1'b1, 1'b0, 1'b0);

    // Fill, overflow three times, then push+pop while full
    for (int i = 0; i < 16; i++) step(2'b01, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b10, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("full_drop", 32'(drop_count), 32'd3);
    check("full_head", 32'(dout), 32'h0110);
    step(2'b10, 8'hAA, 1'b1, 1'b0, 1'b0);
    check("pp_level", 32'(level), 32'd16);
    check("pp_head", 32'(dout), 32'h0111);

    // Drain, then interleave pushes and pops across the pointer wrap
    for (int i = 0; i < 16; i++) step(2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(2'b01, 8'(8'h40 + i), 1'(i % 2), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
    step(2'b11, 8'h99, 1'b1, 1'b0, 1'b0);
    step(2'b01, 8'h55, 1'b0, 1'b1, 1'b0);
    check("clr_level", 32'(level), 32'd0);
    check("clr_drop", 32'(drop_count), 32'd0);

`ifdef EVLOG_TIMESTAMP_EN
    for (int i = 0; i < 5; i++) step(2'b00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(2'b01, 8'h33, 1'b0, 1'b0, 1'b1);
    check("ts_5", 32'(ts_out), 32'h0005);
    step(2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
    tick = 1'b1;
    repeat (65535) @(posedge clk1);
    #1;
    tick = 1'b0;
    m_ts = 16'hFFFF;
    step(2'b01, 8'h01, 1'b0, 1'b0, 1'b1);
    check("ts_ffff", 32'(ts_out), 32'h0000FFFF);
    step(2'b01, 8'h02, 1'b1, 1'b0, 1'b0);
    check("ts_wrap", 32'(ts_out), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
